bus_arbiter_rr: RTL and testbench

- Round-robin arbiter that shares one peripheral register-bus slave port (valid/ready/wstrb/addr/wdata/rdata) among N_MASTERS requesters, e.g. CPU data port plus DMA, in front of the peripheral decoder.
- Serialises requests and returns each response only to the master that issued it.
- Guarantees a one-cycle valid-low gap between transactions, because peripherals register ready from valid.
- A bus timeout completes hung accesses with an error.

---
 rtl/bus_arbiter_rr.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one register-bus slave port among several masters.
// Inserts a one-cycle valid-low gap after each access and times out hung accesses.
module bus_arbiter_rr #(
  parameter int          N_MASTERS    = 2,
  parameter int          TIMEOUT      = 15,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_MASTERS-1:0]      m_valid,
  output logic [N_MASTERS-1:0]      m_ready,
  output logic [N_MASTERS-1:0]      m_err,
  input  logic [4*N_MASTERS-1:0]    m_wstrb,
  input  logic [32*N_MASTERS-1:0]   m_addr,
  input  logic [32*N_MASTERS-1:0]   m_wdata,
  output logic [32*N_MASTERS-1:0]   m_rdata,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic [3:0]                s_wstrb,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic [31:0]               s_rdata
);

  localparam int GW = $clog2(N_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  state_t              state, state_next;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       grant;
  logic [CW-1:0]       counter;
  logic [GW-1:0]       cand;
  logic [GW-1:0]       pick_idx;
  logic                pick_valid;
  logic [N_MASTERS-1:0] grant_onehot;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_wdata;
  logic [3:0]          sel_wstrb;
  logic                timeout_hit;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
    return (i == GW'(N_MASTERS - 1)) ? '0 : i + GW'(1);
  endfunction

  // Search starts one past the last served master so every requester gets its turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = last_grant;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = next_idx(cand);
      if (m_valid[cand] && !pick_valid) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_wstrb    = '0;
    grant_onehot = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (pick_idx == GW'(i)) begin
        sel_addr  = m_addr[i*32 +: 32];
        sel_wdata = m_wdata[i*32 +: 32];
        sel_wstrb = m_wstrb[i*4 +: 4];
      end
      grant_onehot[i] = (grant == GW'(i));
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (counter == TO_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = GRANT;
      GRANT:   if (s_ready || timeout_hit) state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Stale s_ready in RECOVER or IDLE is ignored because only GRANT looks at it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GW'(N_MASTERS - 1);
      grant      <= '0;
      counter    <= '0;
      m_ready    <= '0;
      m_err      <= '0;
      m_rdata    <= '0;
      s_valid    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
    end else begin
      m_ready <= '0;
      m_err   <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant   <= pick_idx;
            s_addr  <= sel_addr;
            s_wdata <= sel_wdata;
            s_wstrb <= sel_wstrb;
            s_valid <= 1'b1;
            counter <= '0;
          end
        end
        GRANT: begin
          if (s_ready || timeout_hit) begin
            for (int i = 0; i < N_MASTERS; i++) begin
              if (grant_onehot[i]) m_rdata[i*32 +: 32] <= s_ready ? s_rdata : TIMEOUT_DATA;
            end
            m_ready    <= grant_onehot;
            m_err      <= s_ready ? '0 : grant_onehot;
            s_valid    <= 1'b0;
            counter    <= '0;
            last_grant <= grant;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: two masters, a slave whose ready is registered from valid.
module tb_bus_arbiter_rr;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    m_valid = '0;
  logic [N-1:0]    m_ready;
  logic [N-1:0]    m_err;
  logic [4*N-1:0]  m_wstrb = '0;
  logic [32*N-1:0] m_addr = '0;
  logic [32*N-1:0] m_wdata = '0;
  logic [32*N-1:0] m_rdata;
  logic            s_valid;
  logic            s_ready = 1'b0;
  logic [3:0]      s_wstrb;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata = '0;
  logic            slave_en = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Slave model: ready follows valid by one cycle, so it lingers one cycle past completion.
  always @(posedge clk) s_ready <= slave_en & s_valid;

  bus_arbiter_rr #(.N_MASTERS(N), .TIMEOUT(15), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_ready(m_ready), .m_err(m_err),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [31:0] a,
                               input logic [31:0] w, input logic [3:0] st);
    m_valid[idx]        = v;
    m_addr[idx*32 +: 32] = a;
    m_wdata[idx*32 +: 32] = w;
    m_wstrb[idx*4 +: 4]  = st;
  endtask

  // Request already presented in the current IDLE cycle; returns in the RECOVER cycle.
  task automatic runTransaction(input int g, input logic [31:0] addr, input logic [31:0] rdata);
    tick();
    checkOutput("txn s_valid", 64'(s_valid), 64'(1));
    checkOutput("txn s_addr", 64'(s_addr), 64'(addr));
    tick();
    checkOutput("txn early m_ready", 64'(m_ready), 64'(0));
    tick();
    checkOutput("txn m_ready", 64'(m_ready), 64'(1) << g);
    checkOutput("txn m_err", 64'(m_err), 64'(0));
    checkOutput("txn recover gap", 64'(s_valid), 64'(0));
    checkOutput("txn m_rdata", 64'(m_rdata[g*32 +: 32]), 64'(rdata));
  endtask

  initial begin
    int cnt;
    logic seen;

    repeat (3) tick();
    checkOutput("reset s_valid", 64'(s_valid), 64'(0));
    checkOutput("reset m_ready", 64'(m_ready), 64'(0));
    checkOutput("reset m_err", 64'(m_err), 64'(0));
    checkOutput("reset m_rdata", 64'(m_rdata), 64'(0));
    checkOutput("reset s_addr", 64'(s_addr), 64'(0));
    reset = 1'b0;

    // Single master 1 write
    s_rdata = 32'h5555_0001;
    applyStimulus(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF);
    tick();
    checkOutput("single s_valid", 64'(s_valid), 64'(1));
    checkOutput("single s_addr", 64'(s_addr), 64'h4);
    checkOutput("single s_wdata", 64'(s_wdata), 64'h1234_5678);
    checkOutput("single s_wstrb", 64'(s_wstrb), 64'hF);
    checkOutput("single m_ready t+1", 64'(m_ready), 64'(0));
    tick();
    checkOutput("single m_ready t+2", 64'(m_ready), 64'(0));
    tick();
    checkOutput("single m_ready t+3", 64'(m_ready), 64'b10);
    checkOutput("single m_err", 64'(m_err), 64'(0));
    checkOutput("single recover s_valid", 64'(s_valid), 64'(0));
    checkOutput("single write latches rdata", 64'(m_rdata[63:32]), 64'h5555_0001);
    tick();
    applyStimulus(1, 1'b0, 32'h0000_0004, 32'h1234_5678, 4'hF);
    checkOutput("single pulse width", 64'(m_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stale no regrant s_valid", 64'(s_valid), 64'(0));
      checkOutput("stale no extra m_ready", 64'(m_ready), 64'(0));
    end

    // Contention: both masters request continuously, grants alternate starting at 0
    s_rdata = 32'h7777_0000;
    applyStimulus(0, 1'b1, 32'h0000_0100, 32'h0000_00A0, 4'hF);
    applyStimulus(1, 1'b1, 32'h0000_0200, 32'h0000_00A1, 4'hF);
    for (int k = 0; k < 4; k++) begin
      runTransaction(k % 2, (k % 2) ? 32'h0000_0200 : 32'h0000_0100, 32'h7777_0000);
      tick();
      checkOutput("contention idle gap", 64'(s_valid), 64'(0));
    end
    m_valid = '0;

    // Read for master 0; master 1 read data must not move
    tick();
    s_rdata = 32'hCAFE_0001;
    applyStimulus(0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
    runTransaction(0, 32'h0000_0010, 32'hCAFE_0001);
    checkOutput("read m_rdata1 held", 64'(m_rdata[63:32]), 64'h7777_0000);
    checkOutput("read s_wstrb", 64'(s_wstrb), 64'h0);
    tick();
    m_valid = '0;

    // Timeout: slave never answers
    tick();
    slave_en = 1'b0;
    applyStimulus(1, 1'b1, 32'h0000_0020, 32'h0000_00BB, 4'hF);
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (m_ready != '0) seen = 1'b1;
      else if (s_valid) cnt++;
    end
    checkOutput("timeout completed", 64'(seen), 64'(1));
    checkOutput("timeout valid cycles", 64'(cnt), 64'd15);
    checkOutput("timeout m_ready", 64'(m_ready), 64'b10);
    checkOutput("timeout m_err", 64'(m_err), 64'b10);
    checkOutput("timeout m_rdata", 64'(m_rdata[63:32]), 64'hDEAD_BEEF);
    checkOutput("timeout s_valid", 64'(s_valid), 64'(0));
    tick();
    m_valid = '0;
    checkOutput("timeout m_err width", 64'(m_err), 64'(0));
    slave_en = 1'b1;
    s_rdata = 32'h0000_0042;
    applyStimulus(0, 1'b1, 32'h0000_0030, 32'h0000_00CC, 4'h3);
    runTransaction(0, 32'h0000_0030, 32'h0000_0042);
    tick();
    m_valid = '0;

    // Reset while a transaction to master 1 is in GRANT
    tick();
    applyStimulus(0, 1'b1, 32'h0000_0100, 32'h0000_00A0, 4'hF);
    applyStimulus(1, 1'b1, 32'h0000_0200, 32'h0000_00A1, 4'hF);
    tick();
    checkOutput("pre-reset grant addr", 64'(s_addr), 64'h200);
    checkOutput("pre-reset s_valid", 64'(s_valid), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("reset abort s_valid", 64'(s_valid), 64'(0));
    checkOutput("reset abort m_ready", 64'(m_ready), 64'(0));
    checkOutput("reset abort m_err", 64'(m_err), 64'(0));
    runTransaction(0, 32'h0000_0100, 32'h0000_0042);
    checkOutput("reset m_rdata1 cleared", 64'(m_rdata[63:32]), 64'(0));
    tick();
    m_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
